router_ctrl: RTL and testbench
==============================

# router_ctrl

Control block for the 1x3 packet router. It decodes the 2-bit destination in each packet header and sequences the input register and the three output FIFOs through header, payload, stall-on-full and parity phases. It generates per-port FIFO write enables and per-port valid flags. It issues a per-port soft reset when a destination leaves its packet unread for too long. It sits between the input interface/register stage and the three 16-deep output FIFOs.

## Interface
- TIMEOUT, 30: consecutive cycles a port may show valid data without a read before its soft reset fires; legal 2..63.

- clock  in  1  rising-edge clock
- resetn  in  1  reset, asynchronous, active-low
- pkt_valid  in  1  header/payload byte valid from source
- data_in  in  2  header address bits [1:0]; sampled only in DECODE_ADDRESS
- parity_done  in  1  parity byte captured by register stage
- low_pkt_valid  in  1  pkt_valid fell while a FIFO was full
- fifo_full  in  3  full flag per FIFO
- fifo_empty  in  3  empty flag per FIFO
- read_enb  in  3  per-port read strobe from destination
- busy  out  1  source must hold its byte
- detect_add, lfd_state, ld_state, laf_state, full_state  out  1 each  state decodes
- write_enb_reg  out  1  register stage writes toward FIFO
- rst_int_reg  out  1  parity check strobe
- write_enb  out  3  one-hot FIFO write enable
- vld_out  out  3  per-port data available
- soft_reset  out  3  per-port FIFO flush pulse

## Operation
- The FSM has 8 binary-encoded states. Transitions:
  - DECODE_ADDRESS: on pkt_valid with data_in=k, k in 0..2, latch addr=k. Go to LOAD_FIRST_DATA if fifo_empty[k], else WAIT_TILL_EMPTY. With data_in=3 or no pkt_valid, stay.
  - WAIT_TILL_EMPTY: go to LOAD_FIRST_DATA when fifo_empty[addr].
  - LOAD_FIRST_DATA: always go to LOAD_DATA.
  - LOAD_DATA: if fifo_full[addr], go to FIFO_FULL_STATE. Else if !pkt_valid, go to LOAD_PARITY. Else stay.
  - FIFO_FULL_STATE: go to LOAD_AFTER_FULL when !fifo_full[addr].
  - LOAD_AFTER_FULL: if parity_done, go to DECODE_ADDRESS. Else if low_pkt_valid, go to LOAD_PARITY. Else go to LOAD_DATA.
  - LOAD_PARITY: always go to CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: go to FIFO_FULL_STATE if fifo_full[addr], else DECODE_ADDRESS.
  - Any state: if soft_reset[addr] is high, go to DECODE_ADDRESS. This overrides all other transitions.
- Outputs are Moore decodes of the current state:
  - detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_FIRST_DATA | LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- write_enb[k] = write_enb_reg & (addr==k). It is one-hot or zero.
- vld_out[k] = !fifo_empty[k]. It is combinational.
- Per-port timeout counter, width 6:
  - Clears when fifo_empty[k] or read_enb[k].
  - Otherwise increments.
  - On the cycle it equals TIMEOUT-1 while still valid and unread: next edge sets soft_reset[k]=1 for exactly one cycle and clears the counter.
- Reset values: state=DECODE_ADDRESS (detect_add=1, all other decodes 0, busy=0), addr=0, counters=0, soft_reset=000, write_enb=000.

## Timing
- The state register, addr, counters and soft_reset are registered. All other outputs are combinational from registered state or from inputs.
- Header sampled at edge N. lfd_state is high in cycle N+1 and ld_state from N+2, if the FIFO was empty.
- The first soft_reset[k] pulse begins TIMEOUT cycles after vld_out[k] rises with read_enb[k] held low.
- Simultaneous events:
  - soft_reset[addr] together with any FSM condition: reset wins.
  - fifo_full[addr] and !pkt_valid together in LOAD_DATA: full wins.
  - read_enb[k] in the same cycle the counter hits TIMEOUT-1: no pulse, counter clears.
- Soft reset on a port other than addr does not affect the FSM.
- Asserting resetn low mid-packet returns everything to reset values immediately. No state is retained.

## Configuration
- ROUTER_CTRL_TIMEOUT_EN defined: timeout counters and soft_reset generation are present as described.
- Not defined: counters are not built, soft_reset is tied to 000, and the FSM soft-reset override is inert.

## Test plan
- Reset then header data_in=1, FIFO 1 empty, 4 payload bytes, parity:
  - Required sequence: DECODE→LFD→LD×4→LOAD_PARITY→CHECK_PARITY_ERROR→DECODE.
  - write_enb=010 for 6 cycles.
  - rst_int_reg pulses once.
- Header data_in=2 with fifo_empty[2]=0:
  - FSM holds WAIT_TILL_EMPTY with busy=1.
  - Dropping fifo_empty[2] low→high moves the FSM to LFD the next edge.
- fifo_full[0] raised during LOAD_DATA:
  - FIFO_FULL_STATE with busy=1 and write_enb=000.
  - Releasing full gives LOAD_AFTER_FULL.
  - low_pkt_valid=1 then gives LOAD_PARITY.
- Header data_in=3 with pkt_valid=1: FSM stays in DECODE_ADDRESS and write_enb stays 000.
- fifo_empty[1]=0, read_enb[1]=0 for 30 cycles (macro defined):
  - soft_reset=010 for one cycle.
  - If addr=1, the FSM returns to DECODE_ADDRESS.
  - With read_enb[1] at cycle 29, no pulse occurs.
- resetn asserted in LOAD_DATA: all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/router_ctrl.sv
// 1x3 router control: header decode FSM, per-port FIFO write enables, valid flags and
// per-port read-timeout soft resets (timeout logic built only with ROUTER_CTRL_TIMEOUT_EN).
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic [2:0] write_enb,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       soft_hit;

`ifdef ROUTER_CTRL_TIMEOUT_EN
  logic [5:0] cnt_q [3];
  logic [2:0] soft_reset_q;

  // A read or an empty FIFO restarts the count; reaching the limit fires one pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
      soft_reset_q <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (fifo_empty[k] || read_enb[k]) begin
          cnt_q[k]        <= '0;
          soft_reset_q[k] <= 1'b0;
        end else if (cnt_q[k] == TO_LAST) begin
          cnt_q[k]        <= '0;
          soft_reset_q[k] <= 1'b1;
        end else begin
          cnt_q[k]        <= cnt_q[k] + 6'd1;
          soft_reset_q[k] <= 1'b0;
        end
      end
    end
  end

  assign soft_reset = soft_reset_q;
  assign soft_hit   = (addr_q == 2'd0 && soft_reset_q[0]) ||
                      (addr_q == 2'd1 && soft_reset_q[1]) ||
                      (addr_q == 2'd2 && soft_reset_q[2]);
`else
  logic unused_tmo;
  assign unused_tmo = ^{read_enb, TO_LAST};
  assign soft_reset = 3'b000;
  assign soft_hit   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && data_in != 2'd3) begin
          addr_d  = data_in;
          state_d = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY:  if (fifo_empty[addr_q]) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:  state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full[addr_q])  state_d = FIFO_FULL_STATE;
        else if (!pkt_valid)    state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE:  if (!fifo_full[addr_q]) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full[addr_q] ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            state_d = DECODE_ADDRESS;
    endcase
    // Flushing the destination FIFO abandons the packet in flight.
    if (soft_hit) begin
      state_d = DECODE_ADDRESS;
      addr_d  = addr_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = lfd_state | ld_state | laf_state | (state_q == LOAD_PARITY);
  assign busy          = !(detect_add | ld_state);
  assign write_enb     = {3{write_enb_reg}} & {addr_q == 2'd2, addr_q == 2'd1, addr_q == 2'd0};
  assign vld_out       = ~fifo_empty;

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: packet walks, stalls, bad address, read timeouts, async reset.
module tb_router_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg;
  logic [2:0] write_enb, vld_out, soft_reset;

  int total    = 0;
  int pass_cnt = 0;

  // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
  localparam logic [7:0] S_DA  = 8'b1000_0000;
  localparam logic [7:0] S_WTE = 8'b0000_0001;
  localparam logic [7:0] S_LFD = 8'b0100_0011;
  localparam logic [7:0] S_LD  = 8'b0010_0010;
  localparam logic [7:0] S_FFS = 8'b0000_1001;
  localparam logic [7:0] S_LAF = 8'b0001_0011;
  localparam logic [7:0] S_LP  = 8'b0000_0011;
  localparam logic [7:0] S_CPE = 8'b0000_0101;

`ifdef ROUTER_CTRL_TIMEOUT_EN
  localparam logic [7:0] SR_P1   = 8'h02;
  localparam logic [7:0] ST_KILL = S_DA;
`else
  localparam logic [7:0] SR_P1   = 8'h00;
  localparam logic [7:0] ST_KILL = S_LD;
`endif

  logic [7:0] st;
  assign st = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy};

  router_ctrl #(.TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .read_enb(read_enb), .busy(busy), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .write_enb(write_enb),
    .vld_out(vld_out), .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    #12;
    chk("rst_state", st, S_DA);
    chk("rst_we", {5'b0, write_enb}, 8'h00);
    chk("rst_soft", {5'b0, soft_reset}, 8'h00);
    chk("rst_vld", {5'b0, vld_out}, 8'h00);

    // Packet to port 1: header, 4 payload bytes, parity.
    @(negedge clock); resetn = 1'b1; pkt_valid = 1'b1; data_in = 2'd1;
    @(negedge clock); chk("t1_lfd", st, S_LFD); chk("t1_we_lfd", {5'b0, write_enb}, 8'h02);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); chk("t1_ld", st, S_LD); chk("t1_we_ld", {5'b0, write_enb}, 8'h02);
      if (i == 3) pkt_valid = 1'b0;
    end
    @(negedge clock); chk("t1_lp", st, S_LP); chk("t1_we_lp", {5'b0, write_enb}, 8'h02);
    @(negedge clock); chk("t1_cpe", st, S_CPE); chk("t1_we_cpe", {5'b0, write_enb}, 8'h00);
    @(negedge clock); chk("t1_da", st, S_DA);

    // Port 2 busy: wait for empty.
    fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
    #1 chk("t2_vld", {5'b0, vld_out}, 8'h04);
    @(negedge clock); chk("t2_wte", st, S_WTE); pkt_valid = 1'b0;
    @(negedge clock); chk("t2_wte_hold", st, S_WTE); fifo_empty = 3'b111;
    @(negedge clock); chk("t2_lfd", st, S_LFD); chk("t2_we", {5'b0, write_enb}, 8'h04);
    @(negedge clock); chk("t2_ld", st, S_LD);
    @(negedge clock); chk("t2_lp", st, S_LP);
    @(negedge clock); chk("t2_cpe", st, S_CPE);
    @(negedge clock); chk("t2_da", st, S_DA);

    // Port 0 with a full stall; full and end-of-packet arrive together.
    pkt_valid = 1'b1; data_in = 2'd0;
    @(negedge clock); chk("t3_lfd", st, S_LFD);
    @(negedge clock); chk("t3_ld", st, S_LD); fifo_full = 3'b001; pkt_valid = 1'b0;
    @(negedge clock); chk("t3_ffs", st, S_FFS); chk("t3_we_ffs", {5'b0, write_enb}, 8'h00);
    @(negedge clock); chk("t3_ffs_hold", st, S_FFS); fifo_full = 3'b000;
    @(negedge clock); chk("t3_laf", st, S_LAF); chk("t3_we_laf", {5'b0, write_enb}, 8'h01);
    low_pkt_valid = 1'b1;
    @(negedge clock); chk("t3_lp", st, S_LP); low_pkt_valid = 1'b0;
    @(negedge clock); chk("t3_cpe", st, S_CPE);
    @(negedge clock); chk("t3_da", st, S_DA);

    // Illegal address 3 is ignored.
    pkt_valid = 1'b1; data_in = 2'd3;
    @(negedge clock); chk("t4_da", st, S_DA); chk("t4_we", {5'b0, write_enb}, 8'h00);
    @(negedge clock); chk("t4_da2", st, S_DA);
    pkt_valid = 1'b0; data_in = 2'd0;

    // Port 1 left unread while FSM idles with addr 0.
    fifo_empty = 3'b101;
    #1 chk("t5_vld", {5'b0, vld_out}, 8'h02);
    repeat (29) @(negedge clock);
    chk("t5_pre", {5'b0, soft_reset}, 8'h00);
    @(negedge clock); chk("t5_pulse", {5'b0, soft_reset}, SR_P1); chk("t5_fsm", st, S_DA);
    @(negedge clock); chk("t5_post", {5'b0, soft_reset}, 8'h00);

    // Read at the last counted cycle suppresses the pulse.
    fifo_empty = 3'b111;
    @(negedge clock); fifo_empty = 3'b101;
    repeat (29) @(negedge clock);
    read_enb = 3'b010;
    @(negedge clock); chk("t5_read_nopulse", {5'b0, soft_reset}, 8'h00);
    read_enb = 3'b000; fifo_empty = 3'b111;

    // Timeout on the port being written aborts the packet.
    @(negedge clock); pkt_valid = 1'b1; data_in = 2'd1;
    @(negedge clock); chk("t6_lfd", st, S_LFD);
    @(negedge clock); chk("t6_ld", st, S_LD); fifo_empty = 3'b101;
    repeat (29) @(negedge clock);
    chk("t6_ld_hold", st, S_LD);
    @(negedge clock); chk("t6_pulse", {5'b0, soft_reset}, SR_P1); chk("t6_ld_pulse", st, S_LD);
    @(negedge clock); chk("t6_kill", st, ST_KILL);
    pkt_valid = 1'b0; fifo_empty = 3'b111;
    repeat (4) @(negedge clock);
    chk("t6_idle", st, S_DA);

    // Asynchronous reset in LOAD_DATA.
    pkt_valid = 1'b1; data_in = 2'd0;
    @(negedge clock); chk("t7_lfd", st, S_LFD);
    @(negedge clock); chk("t7_ld", st, S_LD); chk("t7_we_ld", {5'b0, write_enb}, 8'h01);
    #1 resetn = 1'b0;
    #1 chk("t7_state", st, S_DA);
    chk("t7_we", {5'b0, write_enb}, 8'h00);
    chk("t7_soft", {5'b0, soft_reset}, 8'h00);
    @(negedge clock); resetn = 1'b1; pkt_valid = 1'b0;
    @(negedge clock); chk("t7_after", st, S_DA);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
